// File: rtl/period_meter.sv
// Measures the period and high time of a slow external signal in clk cycles.
// Results are held until the next completed measurement; aborts pulse timeout.
module period_meter #(
    parameter int CNT_W       = 22,
    parameter int TIMEOUT_CYC = 4194303,
    parameter bit CONTINUOUS  = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
    input  logic             start,
    output logic             busy,
    output logic [CNT_W-1:0] period,
    output logic [CNT_W-1:0] high_time,
    output logic             valid,
    output logic             timeout
);

    typedef enum logic [1:0] {
        IDLE,
        ARM,
        MEASURE
    } state_t;

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TIMEOUT_CYC - 1);
    localparam logic [CNT_W-1:0] ONE      = CNT_W'(1);

    state_t           state, state_nx;
    logic             s1, s2, s3;
    logic             rise;
    logic             at_last;
    logic [CNT_W-1:0] cnt, cnt_nx;
    logic [CNT_W-1:0] hi, hi_nx;
    logic [CNT_W-1:0] period_nx, high_nx;
    logic             valid_nx, timeout_nx;

    // Two-flop synchroniser followed by an edge-detect flop.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge value of its neighbours, as real hardware does.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= sig_in;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise    = s2 & ~s3;
    assign at_last = (cnt == LAST_CNT);
    assign busy    = (state != IDLE);

    // NOTE: every output of this block gets a default first; a path that
    // leaves one unassigned would infer a latch.
    always_comb begin
        state_nx   = state;
        cnt_nx     = cnt;
        hi_nx      = hi;
        period_nx  = period;
        high_nx    = high_time;
        valid_nx   = 1'b0;
        timeout_nx = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    state_nx = ARM;
                    cnt_nx   = '0;
                    hi_nx    = '0;
                end
            end
            ARM: begin
                if (rise) begin
                    state_nx = MEASURE;
                    cnt_nx   = ONE;
                    hi_nx    = ONE;
                end else if (at_last) begin
                    timeout_nx = 1'b1;
                    state_nx   = CONTINUOUS ? ARM : IDLE;
                    cnt_nx     = '0;
                end else begin
                    cnt_nx = cnt + ONE;
                end
            end
            MEASURE: begin
                if (rise) begin
                    // The closing rise also opens the next period in continuous mode.
                    period_nx = cnt;
                    high_nx   = hi;
                    valid_nx  = 1'b1;
                    state_nx  = CONTINUOUS ? MEASURE : IDLE;
                    cnt_nx    = ONE;
                    hi_nx     = ONE;
                end else if (at_last) begin
                    timeout_nx = 1'b1;
                    state_nx   = CONTINUOUS ? ARM : IDLE;
                    cnt_nx     = '0;
                end else begin
                    cnt_nx = cnt + ONE;
                    hi_nx  = hi + CNT_W'(s2);
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            cnt       <= '0;
            hi        <= '0;
            period    <= '0;
            high_time <= '0;
            valid     <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            hi        <= hi_nx;
            period    <= period_nx;
            high_time <= high_nx;
            valid     <= valid_nx;
            timeout   <= timeout_nx;
        end
    end

endmodule

// File: tb/tb_period_meter.sv
// Testbench for period_meter: a single-shot and a continuous instance share
// sig_in; results are compared against periods computed from the drive pattern.
module tb_period_meter;

    localparam int CNT_W = 16;
    localparam int TMO   = 100;

    typedef struct {
        bit is_valid;
        int period;
        int high;
        bit busy;
        bit busy_prev;
        int cyc;
    } ev_t;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             sig_in = 1'b0;
    logic             start_ss = 1'b0;
    logic             start_ct = 1'b0;
    logic             ss_busy, ss_valid, ss_timeout;
    logic             ct_busy, ct_valid, ct_timeout;
    logic [CNT_W-1:0] ss_period, ss_high, ct_period, ct_high;

    int  n_checks = 0;
    int  n_errors = 0;
    int  cyc = 0;
    ev_t ss_q[$];
    ev_t ct_q[$];
    bit  ss_busy_d = 1'b0;
    bit  ct_busy_d = 1'b0;

    period_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO), .CONTINUOUS(1'b0)) dut_ss (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start_ss), .busy(ss_busy),
        .period(ss_period), .high_time(ss_high), .valid(ss_valid), .timeout(ss_timeout)
    );

    period_meter #(.CNT_W(CNT_W), .TIMEOUT_CYC(TMO), .CONTINUOUS(1'b1)) dut_ct (
        .clk(clk), .rst(rst), .sig_in(sig_in), .start(start_ct), .busy(ct_busy),
        .period(ct_period), .high_time(ct_high), .valid(ct_valid), .timeout(ct_timeout)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string tag, input longint got, input longint exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // Event log on the falling edge, well away from the active edge.
    always @(negedge clk) begin
        ev_t e;
        if (ss_valid || ss_timeout) begin
            check("ss_valid_timeout_exclusive", ss_valid && ss_timeout, 0);
            e.is_valid = ss_valid; e.period = int'(ss_period); e.high = int'(ss_high);
            e.busy = ss_busy; e.busy_prev = ss_busy_d; e.cyc = cyc;
            ss_q.push_back(e);
        end
        if (ct_valid || ct_timeout) begin
            check("ct_valid_timeout_exclusive", ct_valid && ct_timeout, 0);
            e.is_valid = ct_valid; e.period = int'(ct_period); e.high = int'(ct_high);
            e.busy = ct_busy; e.busy_prev = ct_busy_d; e.cyc = cyc;
            ct_q.push_back(e);
        end
        ss_busy_d = ss_busy;
        ct_busy_d = ct_busy;
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // One square-wave cycle: h sampled-high cycles then l sampled-low cycles.
    // poke adds a start pulse while busy and a sub-cycle glitch in the low phase.
    task automatic wave(input int h, input int l, input bit poke);
        sig_in = 1'b1;
        if (poke) begin
            start_ss = 1'b1;
            step(1);
            start_ss = 1'b0;
            step(h - 1);
        end else begin
            step(h);
        end
        sig_in = 1'b0;
        if (poke) begin
            #2 sig_in = 1'b1;
            #1 sig_in = 1'b0;
        end
        step(l);
    endtask

    task automatic pulse_start_ss();
        start_ss = 1'b1;
        step(1);
        start_ss = 1'b0;
    endtask

    // Single-shot: the first full period after arming is reported, later ones ignored.
    task automatic ss_single(input string tag, input int h, input int l,
                             input int h2, input int l2, input bit poke);
        ss_q.delete();
        pulse_start_ss();
        step(4);
        wave(h, l, poke);
        wave(h2, l2, 1'b0);
        step(10);
        check({tag, "_events"}, ss_q.size(), 1);
        if (ss_q.size() >= 1) begin
            check({tag, "_is_valid"}, ss_q[0].is_valid, 1);
            check({tag, "_period"}, ss_q[0].period, h + l);
            check({tag, "_high"}, ss_q[0].high, h);
            check({tag, "_busy_in_valid"}, ss_q[0].busy, 0);
            check({tag, "_busy_before_valid"}, ss_q[0].busy_prev, 1);
        end
        check({tag, "_idle_after"}, ss_busy, 0);
    endtask

    task automatic ss_timeout_run(input string tag, input int exp_p, input int exp_h);
        int t0;
        ss_q.delete();
        start_ss = 1'b1;
        t0 = cyc + 1;
        step(1);
        start_ss = 1'b0;
        step(TMO + 10);
        check({tag, "_events"}, ss_q.size(), 1);
        if (ss_q.size() >= 1) begin
            check({tag, "_is_timeout"}, ss_q[0].is_valid, 0);
            check({tag, "_latency"}, ss_q[0].cyc - t0, TMO);
        end
        check({tag, "_period_held"}, ss_period, exp_p);
        check({tag, "_high_held"}, ss_high, exp_h);
        check({tag, "_idle_after"}, ss_busy, 0);
    endtask

    initial begin
        int hs[$];
        int ls[$];
        int nv, nt, k;
        ev_t vq[$];

        // Reset state
        step(3);
        check("rst_ss_busy", ss_busy, 0);
        check("rst_ss_period", ss_period, 0);
        check("rst_ss_high", ss_high, 0);
        check("rst_ss_valid", ss_valid, 0);
        check("rst_ss_timeout", ss_timeout, 0);
        check("rst_ct_busy", ct_busy, 0);
        check("rst_ct_period", ct_period, 0);
        #2 rst = 1'b1;
        step(5);

        // Basic 4/4 wave, then the same with start-while-busy and a glitch
        ss_single("basic_4_4", 4, 4, 4, 4, 1'b0);
        ss_single("poke_glitch", 4, 4, 4, 4, 1'b1);

        // Randomised single-shot measurements
        for (int i = 0; i < 6; i++) begin
            int h, l;
            h = int'($urandom_range(1, 30));
            l = int'($urandom_range(1, 30));
            ss_single($sformatf("rand_ss%0d", i), h, l,
                      int'($urandom_range(1, 10)), int'($urandom_range(1, 10)), 1'b0);
        end

        // Period of TMO-1 still completes; TMO aborts with results held
        ss_single("boundary_99", 10, TMO - 11, 5, 5, 1'b0);
        ss_q.delete();
        pulse_start_ss();
        step(4);
        wave(10, TMO - 10, 1'b0);
        wave(5, 5, 1'b0);
        step(10);
        check("period_100_events", ss_q.size(), 1);
        if (ss_q.size() >= 1) check("period_100_is_timeout", ss_q[0].is_valid, 0);
        check("period_100_period_held", ss_period, TMO - 1);
        check("period_100_high_held", ss_high, 10);

        // Timeouts with sig_in stuck low and stuck high
        ss_timeout_run("stuck_low", TMO - 1, 10);
        sig_in = 1'b1;
        step(10);
        ss_timeout_run("stuck_high", TMO - 1, 10);
        sig_in = 1'b0;
        step(5);

        // Asynchronous reset in the middle of a measurement
        ss_q.delete();
        pulse_start_ss();
        step(4);
        sig_in = 1'b1;
        step(5);
        sig_in = 1'b0;
        step(3);
        check("mid_rst_busy_before", ss_busy, 1);
        #2 rst = 1'b0;
        #1;
        check("mid_rst_busy", ss_busy, 0);
        check("mid_rst_period", ss_period, 0);
        check("mid_rst_high", ss_high, 0);
        check("mid_rst_valid", ss_valid, 0);
        check("mid_rst_timeout", ss_timeout, 0);
        step(1);
        rst = 1'b1;
        repeat (4) wave(4, 4, 1'b0);
        step(10);
        check("post_rst_no_events", ss_q.size(), 0);
        check("post_rst_idle", ss_busy, 0);

        // Continuous mode: random periods followed by a 3/13 train, then silence
        ct_q.delete();
        start_ct = 1'b1;
        step(1);
        start_ct = 1'b0;
        step(4);
        for (int i = 0; i < 8; i++) begin
            hs.push_back(int'($urandom_range(1, 30)));
            ls.push_back(int'($urandom_range(1, 30)));
        end
        for (int i = 0; i < 5; i++) begin
            hs.push_back(3);
            ls.push_back(13);
        end
        for (int i = 0; i < hs.size(); i++) wave(hs[i], ls[i], 1'b0);
        step(130);

        nv = 0;
        nt = 0;
        foreach (ct_q[i]) begin
            if (ct_q[i].is_valid) begin
                nv++;
                vq.push_back(ct_q[i]);
            end else begin
                nt++;
            end
        end
        check("ct_valid_count", nv, hs.size() - 1);
        check("ct_timeout_count", nt, 1);
        k = (vq.size() < hs.size() - 1) ? vq.size() : hs.size() - 1;
        for (int i = 0; i < k; i++) begin
            check($sformatf("ct_period%0d", i), vq[i].period, hs[i] + ls[i]);
            check($sformatf("ct_high%0d", i), vq[i].high, hs[i]);
            if (i > 0)
                check($sformatf("ct_spacing%0d", i), vq[i].cyc - vq[i-1].cyc, hs[i] + ls[i]);
        end
        if (ct_q.size() >= 1)
            check("ct_timeout_last", ct_q[ct_q.size()-1].is_valid, 0);
        check("ct_rearmed_busy", ct_busy, 1);
        check("ct_final_period", ct_period, 16);
        check("ct_final_high", ct_high, 3);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
